// File: rtl/mux4_arbiter.sv
// Round-robin / fixed-priority arbiter feeding a shared 4:1 mux onto one valid/ready port.
// Define MUX4_ARBITER_RR_EN for round-robin; otherwise requester 0 has fixed top priority.
module mux4_arbiter #(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_i,
  input  logic [BIT_WIDTH-1:0] in0_i,
  input  logic [BIT_WIDTH-1:0] in1_i,
  input  logic [BIT_WIDTH-1:0] in2_i,
  input  logic [BIT_WIDTH-1:0] in3_i,
  output logic [3:0]           ack_o,
  output logic [1:0]           sel_o,
  output logic                 valid_o,
  output logic [BIT_WIDTH-1:0] data_o,
  input  logic                 ready_i
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e               state_q;
  logic [3:0]           eligible;
  logic                 capture;
  logic [1:0]           winner;
  logic [BIT_WIDTH-1:0] win_data;

  // Masking the requester acked this cycle stops a held req being captured twice.
  assign eligible = req_i & ~ack_o;
  assign capture  = (|eligible) && ((state_q == StIdle) || ready_i);

`ifdef MUX4_ARBITER_RR_EN
  logic [1:0] pointer_q;

  // Scan from farthest to nearest so the first set bit after the pointer wins last.
  always_comb begin
    logic [1:0] idx;
    winner = 2'd0;
    idx    = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = pointer_q + 2'(i);
      if (eligible[idx]) winner = idx;
    end
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) winner = 2'(i);
    end
  end
`endif

  always_comb begin
    case (winner)
      2'd0:    win_data = in0_i;
      2'd1:    win_data = in1_i;
      2'd2:    win_data = in2_i;
      default: win_data = in3_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      valid_o   <= 1'b0;
      data_o    <= '0;
      sel_o     <= 2'd0;
      ack_o     <= 4'd0;
`ifdef MUX4_ARBITER_RR_EN
      pointer_q <= 2'd3;
`endif
    end else begin
      ack_o <= 4'd0;
      if (capture) begin
        state_q   <= StBusy;
        valid_o   <= 1'b1;
        sel_o     <= winner;
        data_o    <= win_data;
        ack_o     <= 4'b0001 << winner;
`ifdef MUX4_ARBITER_RR_EN
        pointer_q <= winner;
`endif
      end else if ((state_q == StBusy) && ready_i) begin
        state_q <= StIdle;
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter and sequencer for a shared 4:1 datapath multiplexer. It accepts requests from up to four requesters and selects one winner. It drives the mux select and a registered copy of the winner's data onto a single downstream valid/ready port. The downstream port is the common memory/bus port used by the non-pipelined core, so fetch, load/store and debug sources can share one path.

## Interface
Parameters:
- BIT_WIDTH, 32, width of each requester data word and of the output word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- req_i  input  4  request per requester; bit n belongs to requester n.
- in0_i, in1_i, in2_i, in3_i  input  BIT_WIDTH  requester data; each must be held stable while its req is high and its ack has not been seen.
- ack_o  output  4  one-hot, one-cycle pulse meaning "your word was captured".
- sel_o  output  2  registered select of the last winner; drives the shared 4:1 mux.
- valid_o  output  1  downstream word valid.
- data_o  output  BIT_WIDTH  registered downstream word.
- ready_i  input  1  downstream accepts the word this cycle when valid_o and ready_i are both high.

## Operation
- FSM states:
  - IDLE: valid_o=0.
  - BUSY: valid_o=1, holding a word.
- Capture event: occurs at a clock edge when (state==IDLE) or (state==BUSY and ready_i==1), and at least one eligible request exists.
- Eligible requests are req_i & ~ack_o. The requester being acked this cycle is masked, so a held req is never captured twice.
- On a capture event:
  - winner w is chosen by the arbitration rule;
  - sel_o<=w, data_o<=in_w, valid_o<=1, ack_o<=onehot(w), pointer<=w;
  - state<=BUSY.
- BUSY, ready_i=1, no eligible request: valid_o<=0, state<=IDLE.
- BUSY, ready_i=0: everything is held (data_o, sel_o, valid_o).
- ack_o is cleared every cycle without a capture event.
- Round-robin arbitration: the search starts at (pointer+1) mod 4 and wraps. The first set eligible bit wins.
- Reset values:
  - state=IDLE, valid_o=0, data_o=0, sel_o=0, ack_o=0;
  - pointer=3, so requester 0 has first priority.
- Reset mid-operation: the held word is discarded, valid_o drops asynchronously, and no ack is issued for the in-flight word.

## Timing
- Latency: a req sampled high at edge k, in IDLE, produces valid_o and ack_o high from edge k to edge k+1.
- Throughput: one word per cycle while ready_i stays high and eligible requests exist.
- A requester must keep req and data until it sees ack. It may drop req in the ack cycle; it may reassert it the next cycle.
- Simultaneous events:
  - a downstream handshake and a new capture on the same edge replace data_o with no bubble;
  - a request arriving while BUSY with ready_i=0 waits.
- Fairness: with all four requesting continuously, each is granted once per 4 captures.
- data_o/sel_o/valid_o never change while valid_o=1 and ready_i=0.

## Configuration
- Macro: MUX4_ARBITER_RR_EN.
- Defined: round-robin arbitration as above; the pointer register is present.
- Undefined: fixed priority, where requester 0 is highest and 3 is lowest.
  - The pointer register is removed.
  - All other behaviour, timing and masking are unchanged.

## Test plan
- Reset: assert rst mid-BUSY with valid_o=1 and data_o=0x1234 -> outputs go to valid_o=0, data_o=0, sel_o=0, ack_o=0 immediately, before the next clk edge.
- Single request:
  - req_i=4'b0100, in2_i=0xCAFE0002, ready_i=1;
  - next cycle: valid_o=1, sel_o=2, data_o=0xCAFE0002, ack_o=4'b0100;
  - requester drops req -> IDLE, valid_o=0 after one further cycle.
- Backpressure: capture in1_i=0xAAAA; hold ready_i=0 for 5 cycles while req_i=4'b1000 -> data_o stays 0xAAAA, sel_o=1, ack_o=0. ready_i=1 -> next word 0x in3_i with ack_o=4'b1000.
- Fairness: req_i=4'b1111 held (re-raised after each ack), ready_i=1 -> sel_o sequence 0,1,2,3,0,1,2,3. With the macro undefined -> sel_o stays 0 whenever req0 is eligible (0,1,0,1... given ack masking).
- Double-capture guard: requester 3 keeps req high through its ack cycle with ready_i=1 and no other request -> exactly one ack_o[3] pulse per two cycles, never on consecutive cycles.
- Wrap-around: pointer=3, req_i=4'b1001 -> requester 0 wins; the next capture with req_i=4'b1001 -> requester 3 wins.
